// File: rtl/ahb_lite_protocol_monitor.sv
// Passive AHB-Lite manager-side protocol monitor: tracks bursts and the two-cycle ERROR
// response, and records rule violations as a bitmap, a saturating count and a first-hit record.
module ahb_lite_protocol_monitor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [7:0]  RULE_EN    = 8'hFF
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic                  clear,
  output logic [7:0]            viol_vec,
  output logic                  viol_valid,
  output logic [CNT_WIDTH-1:0]  viol_count,
  output logic [2:0]            first_code,
  output logic [ADDR_WIDTH-1:0] first_addr,
  output logic                  first_seen,
  output logic                  burst_active,
  output logic [4:0]            beat_cnt
);

  localparam logic [1:0] TrIdle   = 2'd0;
  localparam logic [1:0] TrBusy   = 2'd1;
  localparam logic [1:0] TrNonseq = 2'd2;
  localparam logic [1:0] TrSeq    = 2'd3;
  localparam logic [2:0] BurstSingle = 3'd0;
  localparam logic [3:0] MaxSize = 4'($clog2(DATA_WIDTH / 8));
  localparam int unsigned KbWidth = ADDR_WIDTH - 10;

  typedef enum logic {StIdle, StActive} burst_state_e;
  typedef enum logic {StRespOk, StRespErr2} resp_state_e;

  burst_state_e burst_q, burst_d;
  resp_state_e  resp_q, resp_d;

  logic [2:0]            ctrl_burst_q, ctrl_burst_d;
  logic [2:0]            ctrl_size_q, ctrl_size_d;
  logic                  ctrl_write_q, ctrl_write_d;
  logic [4:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] exp_q, exp_d;
  logic [KbWidth-1:0]    start_kb_q, start_kb_d;

  logic [7:0]            viol_q, viol_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]            code_q, code_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic                  seen_q, seen_d;

  // 0 means unbounded (INCR).
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b[2:1])
      2'b01:   burst_len = 5'd4;
      2'b10:   burst_len = 5'd8;
      2'b11:   burst_len = 5'd16;
      default: burst_len = b[0] ? 5'd0 : 5'd1;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [2:0] b,
                                                       input logic [2:0] s);
    logic [ADDR_WIDTH-1:0] inc, sum, mask;
    inc  = ADDR_WIDTH'(1) << s;
    sum  = a + inc;
    mask = (ADDR_WIDTH'(burst_len(b)) << s) - ADDR_WIDTH'(1);
    if (!b[0] && (b[2:1] != 2'b00)) next_addr = (a & ~mask) | (sum & mask);
    else                            next_addr = sum;
  endfunction

  logic                  is_idle, is_busy, is_nonseq, is_seq, active, fixed, short_burst;
  logic                  err_done, any_viol;
  logic [4:0]            len_q;
  logic [ADDR_WIDTH-1:0] inc_now;
  logic [7:0]            rules;
  logic [2:0]            code_sel;

  assign is_idle     = HTRANS == TrIdle;
  assign is_busy     = HTRANS == TrBusy;
  assign is_nonseq   = HTRANS == TrNonseq;
  assign is_seq      = HTRANS == TrSeq;
  assign active      = burst_q == StActive;
  assign len_q       = burst_len(ctrl_burst_q);
  assign fixed       = ctrl_burst_q[2:1] != 2'b00;
  assign short_burst = fixed && (beat_q < len_q);
  assign inc_now     = ADDR_WIDTH'(1) << HSIZE;
  assign err_done    = (resp_q == StRespErr2) && HRESP && HREADY;

  // Response FSM and rule 6; the ERROR response must be exactly two cycles.
  always_comb begin
    resp_d   = resp_q;
    rules    = 8'h00;
    unique case (resp_q)
      StRespOk: begin
        if (HRESP) begin
          if (HREADY) rules[6] = 1'b1;
          else        resp_d   = StRespErr2;
        end
      end
      StRespErr2: begin
        if (!(HRESP && HREADY)) rules[6] = 1'b1;
        resp_d = StRespOk;
      end
      default: resp_d = StRespOk;
    endcase

    if (HREADY) begin
      rules[0] = (is_seq || is_busy) && !active;
      rules[1] = is_nonseq && active && short_burst && !err_done;
      rules[2] = is_seq && active && (HADDR != exp_q);
      rules[3] = (is_seq || is_busy) && active &&
                 ({HSIZE, HBURST, HWRITE} != {ctrl_size_q, ctrl_burst_q, ctrl_write_q});
      rules[4] = is_idle && active && short_burst && !err_done;
      rules[5] = HTRANS[1] && ({1'b0, HSIZE} > MaxSize);
      rules[7] = HTRANS[1] && (((HADDR & (inc_now - ADDR_WIDTH'(1))) != '0) ||
                 (is_seq && active && ctrl_burst_q[0] &&
                  (HADDR[ADDR_WIDTH-1:10] != start_kb_q)));
    end
  end

  // Burst FSM.
  always_comb begin
    burst_d      = burst_q;
    beat_d       = beat_q;
    ctrl_burst_d = ctrl_burst_q;
    ctrl_size_d  = ctrl_size_q;
    ctrl_write_d = ctrl_write_q;
    exp_d        = exp_q;
    start_kb_d   = start_kb_q;
    if (HREADY) begin
      if (is_nonseq) begin
        beat_d = 5'd1;
        if (HBURST != BurstSingle) begin
          burst_d      = StActive;
          ctrl_burst_d = HBURST;
          ctrl_size_d  = HSIZE;
          ctrl_write_d = HWRITE;
          exp_d        = next_addr(HADDR, HBURST, HSIZE);
          start_kb_d   = HADDR[ADDR_WIDTH-1:10];
        end else begin
          burst_d = StIdle;
        end
      end else if (active && is_seq) begin
        if (beat_q != 5'd31) beat_d = beat_q + 5'd1;
        exp_d = next_addr(exp_q, ctrl_burst_q, ctrl_size_q);
        if (fixed && (beat_q + 5'd1 == len_q)) burst_d = StIdle;
      end else if (active && is_idle) begin
        burst_d = StIdle;
      end
      // A completed ERROR aborts the burst unless a new one starts on this edge.
      if (err_done && !(is_nonseq && HBURST != BurstSingle)) burst_d = StIdle;
    end
  end

  // Violation record.
  always_comb begin
    viol_d   = rules & RULE_EN;
    any_viol = |viol_d;
    code_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (viol_d[i]) code_sel = 3'(i);
    end

    cnt_d   = cnt_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    seen_d  = seen_q;
    if (clear) begin
      cnt_d   = CNT_WIDTH'(any_viol);
      code_d  = 3'd0;
      faddr_d = '0;
      seen_d  = 1'b0;
    end else if (any_viol && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    if (any_viol && (clear || !seen_q)) begin
      code_d  = code_sel;
      faddr_d = HADDR;
      seen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      burst_q      <= StIdle;
      resp_q       <= StRespOk;
      ctrl_burst_q <= 3'd0;
      ctrl_size_q  <= 3'd0;
      ctrl_write_q <= 1'b0;
      beat_q       <= 5'd0;
      exp_q        <= '0;
      start_kb_q   <= '0;
      viol_q       <= 8'h00;
      cnt_q        <= '0;
      code_q       <= 3'd0;
      faddr_q      <= '0;
      seen_q       <= 1'b0;
    end else begin
      burst_q      <= burst_d;
      resp_q       <= resp_d;
      ctrl_burst_q <= ctrl_burst_d;
      ctrl_size_q  <= ctrl_size_d;
      ctrl_write_q <= ctrl_write_d;
      beat_q       <= beat_d;
      exp_q        <= exp_d;
      start_kb_q   <= start_kb_d;
      viol_q       <= viol_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      faddr_q      <= faddr_d;
      seen_q       <= seen_d;
    end
  end

  assign viol_vec     = viol_q;
  assign viol_valid   = |viol_q;
  assign viol_count   = cnt_q;
  assign first_code   = code_q;
  assign first_addr   = faddr_q;
  assign first_seen   = seen_q;
  assign burst_active = burst_q == StActive;
  assign beat_cnt     = beat_q;

endmodule
